// File: rtl/trdb_pkg.sv
// trdb_pkg: shared types and constants for the trace debugger
package trdb_pkg;
  localparam int XLEN = 32;
  localparam int TRDB_MAX_RANGES = 8;
  typedef enum logic [1:0] {WINDOW, START, STOP, RSVD} range_mode_e;
  typedef enum logic [1:0] {IDLE, WAIT_START, TRACING} trig_state_e;
endpackage

// File: rtl/trdb_range_cmp.sv
// trdb_range_cmp: one address range comparator with a saturating hit counter
module trdb_range_cmp #(
  parameter int XLEN = trdb_pkg::XLEN,
  parameter int CNTW = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    ivalid_i,
  input  logic                    en_i,
  input  trdb_pkg::range_mode_e   mode_i,
  input  logic [XLEN-1:0]         addr_i,
  input  logic [XLEN-1:0]         lower_i,
  input  logic [XLEN-1:0]         higher_i,
  output logic                    hit_o,
  output logic [CNTW-1:0]         cnt_o
);
  import trdb_pkg::*;
  logic [CNTW-1:0] cnt_q, cnt_d;
  assign hit_o = en_i && (mode_i != RSVD) && (addr_i >= lower_i) && (addr_i < higher_i);
  always_comb begin
    cnt_d = clear_i ? '0 : (ivalid_i && hit_o && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
  assign cnt_o = cnt_q;
endmodule

// File: rtl/trdb_range_filter.sv
// trdb_range_filter: range/privilege/trigger trace qualification with one cycle latency
module trdb_range_filter #(
  parameter int NRANGES = 4,
  parameter int XLEN    = trdb_pkg::XLEN,
  parameter int CNTW    = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              trace_activated_i,
  input  logic                              apply_filters_i,
  input  logic                              clear_i,
  input  logic                              ivalid_i,
  input  logic [XLEN-1:0]                   iaddr_i,
  input  logic [1:0]                        priv_i,
  input  logic                              trace_selected_priv_i,
  input  logic [1:0]                        which_priv_i,
  input  logic [NRANGES-1:0]                range_en_i,
  input  logic [NRANGES-1:0][1:0]           range_mode_i,
  input  logic [NRANGES-1:0][XLEN-1:0]      range_lower_i,
  input  logic [NRANGES-1:0][XLEN-1:0]      range_higher_i,
  output logic                              ivalid_o,
  output logic [XLEN-1:0]                   iaddr_o,
  output logic                              trace_qualified_o,
  output logic [1:0]                        trig_state_o,
  output logic [NRANGES-1:0][CNTW-1:0]      range_hits_o
);
  import trdb_pkg::*;
  logic [NRANGES-1:0] hit, win_en, win_hit, start_en, start_m, stop_m;
  logic win_ok, priv_ok, start_hit, stop_hit, any_start_en, trig_ok, q;
  trig_state_e state_q, state_d;
  logic ivalid_q, qual_q;
  logic [XLEN-1:0] iaddr_q;
  for (genvar k = 0; k < NRANGES; k++) begin : g_rng
    trdb_range_cmp #(.XLEN(XLEN), .CNTW(CNTW)) u_cmp (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (clear_i),
      .ivalid_i (ivalid_i),
      .en_i     (range_en_i[k]),
      .mode_i   (range_mode_e'(range_mode_i[k])),
      .addr_i   (iaddr_i),
      .lower_i  (range_lower_i[k]),
      .higher_i (range_higher_i[k]),
      .hit_o    (hit[k]),
      .cnt_o    (range_hits_o[k])
    );
    assign win_en[k]   = range_en_i[k] && (range_mode_i[k] == WINDOW);
    assign start_en[k] = range_en_i[k] && (range_mode_i[k] == START);
    assign win_hit[k]  = hit[k] && (range_mode_i[k] == WINDOW);
    assign start_m[k]  = hit[k] && (range_mode_i[k] == START);
    assign stop_m[k]   = hit[k] && (range_mode_i[k] == STOP);
  end
  assign win_ok       = ~|win_en || |win_hit;
  assign priv_ok      = !trace_selected_priv_i || (priv_i == which_priv_i);
  assign start_hit    = ivalid_i && |start_m;
  assign stop_hit     = ivalid_i && |stop_m;
  assign any_start_en = |start_en;
  assign trig_ok      = (state_q == TRACING) || ((state_q == WAIT_START) && start_hit);
  assign q            = apply_filters_i ? (trace_activated_i && win_ok && priv_ok && trig_ok) : trace_activated_i;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       state_d = any_start_en ? WAIT_START : TRACING;
      WAIT_START: state_d = (start_hit && !stop_hit) ? TRACING : WAIT_START;
      TRACING:    state_d = (stop_hit && any_start_en) ? WAIT_START : TRACING;
      default:    state_d = IDLE;
    endcase
    if (!trace_activated_i || clear_i) state_d = IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      ivalid_q <= 1'b0;
      iaddr_q  <= '0;
      qual_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ivalid_q <= ivalid_i;
      iaddr_q  <= iaddr_i;
      qual_q   <= q && ivalid_i;
    end
  end
  assign ivalid_o          = ivalid_q;
  assign iaddr_o           = iaddr_q;
  assign trace_qualified_o = qual_q;
  assign trig_state_o      = state_q;
endmodule

// File: tb/tb_trdb_range_filter.sv
// tb_trdb_range_filter: directed and randomized checks against a behavioural model
module tb_trdb_range_filter;
  localparam int NR = 4;
  localparam int XL = 32;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;
  logic clk_i = 1'b0;
  logic rst_ni, act, apply, clear, ivalid, sel;
  logic [XL-1:0] iaddr;
  logic [1:0] priv, which;
  logic [NR-1:0] en;
  logic [NR-1:0][1:0] mode;
  logic [NR-1:0][XL-1:0] lo, hi;
  logic ivalid_o, q_o;
  logic [XL-1:0] iaddr_o;
  logic [1:0] st_o;
  logic [NR-1:0][CW-1:0] hits_o;
  int n_vec = 0, n_err = 0;
  int m_st;
  int m_hits[NR];
  logic m_iv, m_q;
  logic [XL-1:0] m_ia;

  trdb_range_filter #(.NRANGES(NR), .XLEN(XL), .CNTW(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .trace_activated_i(act), .apply_filters_i(apply),
    .clear_i(clear), .ivalid_i(ivalid), .iaddr_i(iaddr), .priv_i(priv),
    .trace_selected_priv_i(sel), .which_priv_i(which), .range_en_i(en),
    .range_mode_i(mode), .range_lower_i(lo), .range_higher_i(hi),
    .ivalid_o(ivalid_o), .iaddr_o(iaddr_o), .trace_qualified_o(q_o),
    .trig_state_o(st_o), .range_hits_o(hits_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic bit in_rng(int k);
    return en[k] && mode[k] != 2'd3 && iaddr >= lo[k] && iaddr < hi[k];
  endfunction

  // Reference: evaluate the instruction on the current inputs, then advance one clock.
  // States: 0 idle, 1 waiting for start, 2 tracing.
  task automatic tick;
    bit any_win = 0, win = 0, sh = 0, ph = 0, anys = 0, trig, qq;
    bit hv[NR];
    int nst;
    for (int k = 0; k < NR; k++) begin
      hv[k] = in_rng(k);
      if (en[k] && mode[k] == 2'd0) any_win = 1;
      if (en[k] && mode[k] == 2'd1) anys = 1;
      if (hv[k] && mode[k] == 2'd0) win = 1;
      if (hv[k] && mode[k] == 2'd1 && ivalid) sh = 1;
      if (hv[k] && mode[k] == 2'd2 && ivalid) ph = 1;
    end
    trig = (m_st == 2) || (m_st == 1 && sh);
    qq = apply ? (act && (!any_win || win) && (!sel || priv == which) && trig) : act;
    if (clear || !act) nst = 0;
    else if (m_st == 0) nst = anys ? 1 : 2;
    else if (m_st == 1) nst = (sh && !ph) ? 2 : 1;
    else nst = (ph && anys) ? 1 : 2;
    @(posedge clk_i);
    m_st = nst;
    m_q = qq && ivalid;
    m_iv = ivalid;
    m_ia = iaddr;
    for (int k = 0; k < NR; k++)
      m_hits[k] = clear ? 0 : (ivalid && hv[k] && m_hits[k] < SAT) ? m_hits[k] + 1 : m_hits[k];
    #1;
  endtask

  task automatic do_reset;
    act = 0; apply = 0; clear = 0; ivalid = 0; iaddr = '0; priv = 0; which = 0; sel = 0;
    en = '0; mode = '0; lo = '0; hi = '0;
    rst_ni = 0;
    #7;
    rst_ni = 1;
    m_st = 0; m_q = 0; m_iv = 0; m_ia = '0;
    for (int k = 0; k < NR; k++) m_hits[k] = 0;
  endtask

  task automatic test_reset;
    do_reset();
    n_vec++;
    if ({ivalid_o, q_o, iaddr_o, st_o, hits_o} !== '0) begin
      n_err++;
      $display("FAIL reset: iv=%b q=%b ia=%h st=%0d hits=%h required all zero", ivalid_o, q_o, iaddr_o, st_o, hits_o);
    end
  endtask

  task automatic test_passthrough;
    do_reset();
    act = 1; apply = 0; ivalid = 1;
    for (int i = 0; i < 4; i++) begin
      iaddr = 32'h100 + 32'(4 * i);
      tick();
      n_vec++;
      if (q_o !== 1'b1 || ivalid_o !== 1'b1 || iaddr_o !== 32'h100 + 32'(4 * i)) begin
        n_err++;
        $display("FAIL passthrough[%0d]: q=%b iv=%b ia=%h required 1 1 %h", i, q_o, ivalid_o, iaddr_o, 32'h100 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_window;
    logic [XL-1:0] a[4] = '{32'h0FFC, 32'h1000, 32'h1FFC, 32'h2000};
    logic [3:0] exp = 4'b0110;
    do_reset();
    act = 1; apply = 1;
    en[0] = 1; mode[0] = 2'd0; lo[0] = 32'h1000; hi[0] = 32'h2000;
    tick();
    ivalid = 1;
    for (int i = 0; i < 4; i++) begin
      iaddr = a[i];
      tick();
      n_vec++;
      if (q_o !== exp[i]) begin
        n_err++;
        $display("FAIL window[%0d]: q=%b required %b", i, q_o, exp[i]);
      end
    end
    n_vec++;
    if (hits_o[0] !== 4'd2) begin
      n_err++;
      $display("FAIL window_hits: got %0d required 2", hits_o[0]);
    end
  endtask

  task automatic test_start_stop;
    logic [XL-1:0] a[5] = '{32'h300, 32'h400, 32'h500, 32'h800, 32'h900};
    logic [4:0] expq = 5'b01110;
    int exps[5] = '{1, 2, 2, 1, 1};
    do_reset();
    act = 1; apply = 1;
    en[1] = 1; mode[1] = 2'd1; lo[1] = 32'h400; hi[1] = 32'h404;
    en[2] = 1; mode[2] = 2'd2; lo[2] = 32'h800; hi[2] = 32'h804;
    tick();
    n_vec++;
    if (st_o !== 2'd1) begin
      n_err++;
      $display("FAIL start_stop_arm: state=%0d required 1", st_o);
    end
    ivalid = 1;
    for (int i = 0; i < 5; i++) begin
      iaddr = a[i];
      tick();
      n_vec++;
      if (q_o !== expq[i] || st_o !== 2'(exps[i])) begin
        n_err++;
        $display("FAIL start_stop[%0d]: q=%b state=%0d required %b %0d", i, q_o, st_o, expq[i], exps[i]);
      end
    end
    lo[2] = 32'h400; hi[2] = 32'h404; iaddr = 32'h400;
    tick();
    n_vec++;
    if (q_o !== 1'b1 || st_o !== 2'd1) begin
      n_err++;
      $display("FAIL start_stop_same: q=%b state=%0d required 1 1", q_o, st_o);
    end
  endtask

  task automatic test_priv;
    do_reset();
    act = 1; apply = 1; sel = 1; which = 2'd3;
    tick();
    ivalid = 1; iaddr = 32'h40;
    for (int i = 0; i < 6; i++) begin
      priv = (i % 2 == 0) ? 2'd3 : 2'd0;
      tick();
      n_vec++;
      if (q_o !== 1'((i + 1) % 2)) begin
        n_err++;
        $display("FAIL priv[%0d]: q=%b required %0d", i, q_o, (i + 1) % 2);
      end
    end
  endtask

  task automatic test_sat_clear;
    do_reset();
    act = 1;
    en[0] = 1; mode[0] = 2'd0; lo[0] = 32'h1000; hi[0] = 32'h2000;
    ivalid = 1; iaddr = 32'h1004;
    repeat (3) tick();
    clear = 1;
    tick();
    clear = 0;
    n_vec++;
    if (hits_o[0] !== 4'd0 || st_o !== 2'd0) begin
      n_err++;
      $display("FAIL clear_mid: hits=%0d state=%0d required 0 0", hits_o[0], st_o);
    end
    repeat (20) tick();
    n_vec++;
    if (hits_o[0] !== 4'(SAT)) begin
      n_err++;
      $display("FAIL saturate: hits=%0d required %0d", hits_o[0], SAT);
    end
    clear = 1;
    tick();
    clear = 0;
    n_vec++;
    if (hits_o[0] !== 4'd0 || st_o !== 2'd0) begin
      n_err++;
      $display("FAIL clear_sat: hits=%0d state=%0d required 0 0", hits_o[0], st_o);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    act = 1; apply = 1;
    en[1] = 1; mode[1] = 2'd1; lo[1] = 32'h400; hi[1] = 32'h404;
    tick();
    ivalid = 1; iaddr = 32'h400;
    tick();
    iaddr = 32'h500;
    tick();
    n_vec++;
    if (st_o !== 2'd2 || q_o !== 1'b1 || hits_o[1] !== 4'd1) begin
      n_err++;
      $display("FAIL pre_reset: state=%0d q=%b hits=%0d required 2 1 1", st_o, q_o, hits_o[1]);
    end
    #2 rst_ni = 0;
    #1;
    n_vec++;
    if ({ivalid_o, q_o, iaddr_o, st_o, hits_o} !== '0) begin
      n_err++;
      $display("FAIL reset_mid: iv=%b q=%b ia=%h st=%0d hits=%h required all zero", ivalid_o, q_o, iaddr_o, st_o, hits_o);
    end
    #2 rst_ni = 1;
    m_st = 0; m_q = 0; m_iv = 0; m_ia = '0;
    for (int k = 0; k < NR; k++) m_hits[k] = 0;
    ivalid = 0;
    tick();
    n_vec++;
    if (st_o !== 2'd1) begin
      n_err++;
      $display("FAIL reset_rearm: state=%0d required 1", st_o);
    end
  endtask

  task automatic test_random;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c % 40 == 0) begin
        apply = 1'($urandom_range(0, 3) != 0);
        sel = 1'($urandom);
        which = 2'($urandom);
        for (int k = 0; k < NR; k++) begin
          en[k] = 1'($urandom);
          mode[k] = 2'($urandom);
          lo[k] = 32'($urandom_range(0, 48));
          hi[k] = 32'($urandom_range(0, 63));
        end
      end
      act = 1'($urandom_range(0, 24) != 0);
      clear = 1'($urandom_range(0, 59) == 0);
      ivalid = 1'($urandom_range(0, 3) != 0);
      iaddr = 32'($urandom_range(0, 63));
      priv = 2'($urandom);
      tick();
      n_vec++;
      if (ivalid_o !== m_iv || iaddr_o !== m_ia || q_o !== m_q || st_o !== 2'(m_st)) begin
        n_err++;
        $display("FAIL random[%0d]: iv=%b ia=%h q=%b st=%0d required %b %h %b %0d",
                 c, ivalid_o, iaddr_o, q_o, st_o, m_iv, m_ia, m_q, m_st);
      end
      for (int k = 0; k < NR; k++) begin
        n_vec++;
        if (hits_o[k] !== 4'(m_hits[k])) begin
          n_err++;
          $display("FAIL random_hits[%0d][%0d]: got %0d required %0d", c, k, hits_o[k], m_hits[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_window();
    test_start_stop();
    test_priv();
    test_sat_clear();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/trdb_range_filter.md
Name: trdb_range_filter

Overview:
- Parametrised trace qualification filter with NRANGES independent address comparators, privilege matching and start/stop trigger sequencing.
- Sits between the core instruction interface and the packet emitter.
- Registers one qualified/unqualified decision per retired instruction, with one cycle of latency.
- Keeps a per-range saturating hit counter for debug readback over the APB register file.

Parameters:
- NRANGES, 4: number of address range comparators (1..8).
- XLEN, trdb_pkg::XLEN: address width.
- CNTW, 16: width of each per-range hit counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- trace_activated_i  in  1  user master enable
- apply_filters_i  in  1  0: qualification equals trace_activated_i only
- clear_i  in  1  synchronous clear of hit counters and trigger FSM
- ivalid_i  in  1  instruction retired this cycle
- iaddr_i  in  XLEN  instruction address
- priv_i  in  2  current privilege
- trace_selected_priv_i  in  1  restrict tracing to which_priv_i
- which_priv_i  in  2  privilege to trace
- range_en_i  in  NRANGES  per-range enable
- range_mode_i  in  NRANGES x 2  per-range mode (range_mode_e)
- range_lower_i  in  NRANGES x XLEN  inclusive lower bound
- range_higher_i  in  NRANGES x XLEN  exclusive upper bound
- ivalid_o  out  1  registered ivalid_i
- iaddr_o  out  XLEN  registered iaddr_i
- trace_qualified_o  out  1  registered qualification; meaningful only when ivalid_o=1
- trig_state_o  out  2  current trigger FSM state (trig_state_e)
- range_hits_o  out  NRANGES x CNTW  per-range hit counters

Behaviour:
- Reset values: ivalid_o=0, iaddr_o=0, trace_qualified_o=0, trig_state_o=IDLE, all range_hits_o=0.
- Range hit: hit[k] = range_en_i[k] && lower[k] <= iaddr_i < higher[k], unsigned compare. lower >= higher means the range never hits.
- Range modes:
  - WINDOW=0: qualify only while inside the range.
  - START=1: trigger turns tracing on.
  - STOP=2: trigger turns tracing off.
  - 3 is reserved and treated as disabled.
- Window check: win_ok = OR of window-mode hits. win_ok=1 if no window-mode range is enabled.
- Privilege check: priv_ok = !trace_selected_priv_i || (priv_i == which_priv_i).
- Start and stop detection:
  - start_hit = any START-mode hit and ivalid_i.
  - stop_hit = any STOP-mode hit and ivalid_i.
  - any_start_en = some enabled range is START-mode.
- Trigger FSM states:
  - IDLE:
    - trace_activated_i=1 and any_start_en goes to WAIT_START.
    - trace_activated_i=1 and no start range enabled goes to TRACING.
  - WAIT_START:
    - start_hit && !stop_hit goes to TRACING.
    - Otherwise stays in WAIT_START.
  - TRACING:
    - stop_hit goes to WAIT_START if any_start_en, else stays in TRACING.
- FSM overrides:
  - trace_activated_i=0 forces IDLE the next cycle from any state.
  - clear_i forces IDLE and has priority over every other transition.
- trig_ok (combinational) = (state==TRACING) || (state==WAIT_START && start_hit).
  - The start instruction is traced (inclusive).
  - The stop instruction is traced (inclusive).
  - Start and stop on the same instruction in WAIT_START: that instruction is traced and the state stays WAIT_START.
- Qualification:
  - apply_filters_i=0: q = trace_activated_i.
  - Otherwise: q = trace_activated_i && win_ok && priv_ok && trig_ok.
- Output register: every cycle, ivalid_o<=ivalid_i, iaddr_o<=iaddr_i, trace_qualified_o<=q && ivalid_i. Latency is exactly 1 cycle, with no backpressure.
- Hit counters:
  - On ivalid_i && hit[k], counter k increments by 1 and saturates at 2^CNTW-1 (no wrap).
  - Counters count regardless of apply_filters_i and FSM state.
  - clear_i zeroes all counters and wins over a simultaneous increment.
- Reset mid-operation: asynchronous, returns all state to the reset values immediately. Outputs are valid again from the first clock edge after deassertion.
- Configuration inputs are quasi-static. Changes take effect on the next evaluated instruction, with no glitch handling required.

Decomposition:
- trdb_pkg gains:
  - range_mode_e (WINDOW, START, STOP, RSVD)
  - trig_state_e (IDLE, WAIT_START, TRACING)
  - TRDB_MAX_RANGES=8
- Sub-module trdb_range_cmp: one comparator plus its saturating hit counter. It is instantiated NRANGES times in a generate loop. The FSM and qualification logic live in the top module.

Test Plan:
- Passthrough: apply_filters_i=0, trace_activated_i=1, ivalid every cycle at 0x100..0x10C -> trace_qualified_o=1 one cycle after each, iaddr_o matches delayed.
- Window: range0 WINDOW [0x1000,0x2000), addrs 0x0FFC, 0x1000, 0x1FFC, 0x2000 -> qualified 0,1,1,0; range_hits_o[0]=2.
- Start/stop: range1 START [0x400,0x404), range2 STOP [0x800,0x804); stream 0x300, 0x400, 0x500, 0x800, 0x900 -> qualified 0,1,1,1,0; trig_state_o goes WAIT_START -> TRACING -> WAIT_START.
- Privilege: trace_selected_priv_i=1, which_priv_i=3, priv_i alternating 3/0 -> qualified 1/0 alternating.
- Saturation and clear: CNTW=4, 20 hits in range0 -> range_hits_o[0]=15. clear_i asserted on a hit cycle -> 0 the next cycle, trig_state_o=IDLE.
- Reset mid-trace: assert rst_ni=0 while in TRACING with ivalid_i=1 -> all outputs 0 and IDLE immediately. After release, with the START range enabled, the FSM re-enters WAIT_START.
